// File: rtl/snn_timestep_ctrl_if.sv
// Handshake and status bundle between the timestep sequencer and its controller.
interface snn_timestep_ctrl_if;
    logic        start;
    logic        abort;
    logic        busy;
    logic        counter_clear;
    logic        spike_gate;
    logic        global_leak_time;
    logic [7:0]  step_idx;
    logic        sample_done;
    logic [15:0] sample_count;

    modport master (
        output start,
        output abort,
        input  busy,
        input  counter_clear,
        input  spike_gate,
        input  global_leak_time,
        input  step_idx,
        input  sample_done,
        input  sample_count
    );

    modport slave (
        input  start,
        input  abort,
        output busy,
        output counter_clear,
        output spike_gate,
        output global_leak_time,
        output step_idx,
        output sample_done,
        output sample_count
    );
endinterface

// File: rtl/snn_timestep_ctrl.sv
// Timestep sequencer feeding the spike counter / classifier stage.
// Per sample: clear counters, then STEPS_PER_SAMPLE x (integrate, leak),
// then hold the leak strobe while the downstream argmax settles.
module snn_timestep_ctrl #(
    parameter int unsigned STEP_CYCLES      = 64,
    parameter int unsigned LEAK_CYCLES      = 4,
    parameter int unsigned STEPS_PER_SAMPLE = 20,
    parameter int unsigned CLR_CYCLES       = 1,
    parameter int unsigned RESULT_CYCLES    = 12
) (
    input  logic                 CLK,
    input  logic                 RST_sync,
    snn_timestep_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        INTEG = 3'd2,
        LEAK  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [15:0] CLR_LAST    = 16'(CLR_CYCLES - 1);
    localparam logic [15:0] STEP_LAST   = 16'(STEP_CYCLES - 1);
    localparam logic [15:0] LEAK_LAST   = 16'(LEAK_CYCLES - 1);
    localparam logic [15:0] RESULT_LAST = 16'(RESULT_CYCLES - 1);
    localparam logic [7:0]  STEP_IDX_LAST = 8'(STEPS_PER_SAMPLE - 1);

    state_t      state, state_nxt;
    logic [15:0] cyc, cyc_nxt;
    logic [7:0]  step_idx_q, step_idx_nxt;
    logic [15:0] sample_count_q, sample_count_nxt;
    logic        busy_q, busy_nxt;
    logic        clear_q, clear_nxt;
    logic        gate_q, gate_nxt;
    logic        leak_q, leak_nxt;
    logic        done_q, done_nxt;

    // Next-state, counters and registered-output decode.
    always_comb begin
        state_nxt        = state;
        cyc_nxt          = cyc + 16'd1;
        step_idx_nxt     = step_idx_q;
        sample_count_nxt = sample_count_q;
        done_nxt         = 1'b0;

        case (state)
            IDLE: begin
                cyc_nxt = 16'd0;
                if (bus.start && !bus.abort) begin
                    state_nxt    = CLEAR;
                    step_idx_nxt = 8'd0;
                end
            end
            CLEAR: begin
                if (cyc == CLR_LAST) begin
                    state_nxt = INTEG;
                    cyc_nxt   = 16'd0;
                end
            end
            INTEG: begin
                if (cyc == STEP_LAST) begin
                    state_nxt = LEAK;
                    cyc_nxt   = 16'd0;
                end
            end
            LEAK: begin
                if (cyc == LEAK_LAST) begin
                    cyc_nxt = 16'd0;
                    if (step_idx_q == STEP_IDX_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt    = INTEG;
                        step_idx_nxt = step_idx_q + 8'd1;
                    end
                end
            end
            DONE: begin
                if (cyc == RESULT_LAST) begin
                    state_nxt        = IDLE;
                    cyc_nxt          = 16'd0;
                    done_nxt         = 1'b1;
                    sample_count_nxt = sample_count_q + 16'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cyc_nxt   = 16'd0;
            end
        endcase

        // Abort drops straight back to IDLE without completing the sample.
        if (state != IDLE && bus.abort) begin
            state_nxt        = IDLE;
            cyc_nxt          = 16'd0;
            step_idx_nxt     = step_idx_q;
            sample_count_nxt = sample_count_q;
            done_nxt         = 1'b0;
        end

        busy_nxt  = (state_nxt != IDLE);
        clear_nxt = (state_nxt == CLEAR);
        gate_nxt  = (state_nxt == INTEG);
        leak_nxt  = (state_nxt == LEAK) || (state_nxt == DONE);
    end

    // State, counters and output registers; asynchronous reset clears all.
    always_ff @(posedge CLK or posedge RST_sync) begin
        if (RST_sync) begin
            state          <= IDLE;
            cyc            <= 16'd0;
            step_idx_q     <= 8'd0;
            sample_count_q <= 16'd0;
            busy_q         <= 1'b0;
            clear_q        <= 1'b0;
            gate_q         <= 1'b0;
            leak_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state          <= state_nxt;
            cyc            <= cyc_nxt;
            step_idx_q     <= step_idx_nxt;
            sample_count_q <= sample_count_nxt;
            busy_q         <= busy_nxt;
            clear_q        <= clear_nxt;
            gate_q         <= gate_nxt;
            leak_q         <= leak_nxt;
            done_q         <= done_nxt;
        end
    end

    assign bus.busy             = busy_q;
    assign bus.counter_clear    = clear_q;
    assign bus.spike_gate       = gate_q;
    assign bus.global_leak_time = leak_q;
    assign bus.step_idx         = step_idx_q;
    assign bus.sample_done      = done_q;
    assign bus.sample_count     = sample_count_q;

endmodule

// File: tb/tb_snn_timestep_ctrl.sv
// Scoreboard bench for snn_timestep_ctrl using a small timestep configuration.
module tb_snn_timestep_ctrl;

    localparam int STEP   = 4;
    localparam int LEAK   = 2;
    localparam int STEPS  = 3;
    localparam int CLR    = 1;
    localparam int RESULT = 12;
    localparam int SL        = STEP + LEAK;
    localparam int LAST_BUSY = CLR + STEPS * SL + RESULT;

    typedef struct packed {
        logic        busy;
        logic        clear;
        logic        gate;
        logic        leak;
        logic        done;
        logic [7:0]  step;
        logic [15:0] count;
    } exp_t;

    logic CLK;
    logic RST_sync;

    snn_timestep_ctrl_if bus ();

    snn_timestep_ctrl #(
        .STEP_CYCLES      (STEP),
        .LEAK_CYCLES      (LEAK),
        .STEPS_PER_SAMPLE (STEPS),
        .CLR_CYCLES       (CLR),
        .RESULT_CYCLES    (RESULT)
    ) dut (
        .CLK      (CLK),
        .RST_sync (RST_sync),
        .bus      (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int          n_vec = 0;
    int          n_bad = 0;
    exp_t        sb[$];
    logic        act = 1'b0;
    int          k = 0;
    logic [7:0]  last_step = 8'd0;
    logic [15:0] exp_count = 16'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Expected outputs for busy cycle k (k=1 is the first CLEAR cycle).
    function automatic exp_t busy_vec(input int kk, input logic [15:0] cnt);
        exp_t v;
        int   j;
        v       = '0;
        v.busy  = 1'b1;
        v.count = cnt;
        if (kk <= CLR) begin
            v.clear = 1'b1;
        end else begin
            j = kk - CLR - 1;
            if (j < STEPS * SL) begin
                v.step = 8'(j / SL);
                if ((j % SL) < STEP) v.gate = 1'b1;
                else                 v.leak = 1'b1;
            end else begin
                v.step = 8'(STEPS - 1);
                v.leak = 1'b1;
            end
        end
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  32'(bus.busy), 32'd0);
        chk({tag, "_clear"}, 32'(bus.counter_clear), 32'd0);
        chk({tag, "_gate"},  32'(bus.spike_gate), 32'd0);
        chk({tag, "_leak"},  32'(bus.global_leak_time), 32'd0);
        chk({tag, "_step"},  32'(bus.step_idx), 32'd0);
        chk({tag, "_done"},  32'(bus.sample_done), 32'd0);
        chk({tag, "_count"}, 32'(bus.sample_count), 32'd0);
    endtask

    // Drive one cycle of inputs, predict the next cycle, then compare it.
    task automatic tick(input logic st, input logic ab);
        exp_t v;
        exp_t e;
        bus.start = st;
        bus.abort = ab;
        v       = '0;
        v.step  = last_step;
        v.count = exp_count;
        if (act) begin
            if (ab) begin
                act = 1'b0;
            end else if (k == LAST_BUSY) begin
                act       = 1'b0;
                exp_count = exp_count + 16'd1;
                v.count   = exp_count;
                v.done    = 1'b1;
            end else begin
                k = k + 1;
                v = busy_vec(k, exp_count);
            end
        end else if (st && !ab) begin
            act = 1'b1;
            k   = 1;
            v   = busy_vec(1, exp_count);
        end
        if (v.busy) last_step = v.step;
        sb.push_back(v);
        @(negedge CLK);
        e = sb.pop_front();
        chk("busy",  32'(bus.busy), 32'(e.busy));
        chk("clear", 32'(bus.counter_clear), 32'(e.clear));
        chk("gate",  32'(bus.spike_gate), 32'(e.gate));
        chk("leak",  32'(bus.global_leak_time), 32'(e.leak));
        chk("step",  32'(bus.step_idx), 32'(e.step));
        chk("done",  32'(bus.sample_done), 32'(e.done));
        chk("count", 32'(bus.sample_count), 32'(e.count));
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        RST_sync  = 1'b1;
        @(negedge CLK);
        check_all_zero("reset");
        @(negedge CLK);
        RST_sync = 1'b0;
        run_idle(2);

        // Basic sample: start at cycle 0, done at cycle 32.
        tick(1'b1, 1'b0);
        run_idle(32);
        run_idle(2);

        // Back-to-back: start held; second CLEAR at 33, second done at 64.
        for (int i = 0; i < 65; i++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        run_idle(2);

        // Abort at cycle 10, then a complete sample.
        tick(1'b1, 1'b0);
        run_idle(9);
        tick(1'b0, 1'b1);
        run_idle(3);
        tick(1'b1, 1'b0);
        run_idle(33);

        // Start while busy at cycle 20 is ignored; start+abort in IDLE stays IDLE.
        tick(1'b1, 1'b0);
        run_idle(19);
        tick(1'b1, 1'b0);
        run_idle(14);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        run_idle(2);

        // Asynchronous reset in cycle 15 of a sample.
        tick(1'b1, 1'b0);
        run_idle(14);
        #1 RST_sync = 1'b1;
        #1 check_all_zero("async_rst");
        act       = 1'b0;
        last_step = 8'd0;
        exp_count = 16'd0;
        @(negedge CLK);
        check_all_zero("rst_hold");
        RST_sync = 1'b0;
        run_idle(3);
        tick(1'b1, 1'b0);
        run_idle(33);

        // Counter wrap: preload 0xFFFF, then one sample gives 0x0000 with done.
        force dut.sample_count_q = 16'hFFFF;
        exp_count = 16'hFFFF;
        tick(1'b0, 1'b0);
        release dut.sample_count_q;
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        run_idle(33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/snn_timestep_ctrl.md
# snn_timestep_ctrl

Timestep sequencer directly upstream of the spike counter / classifier stage. For each input sample it does four things in order: clears the per-neuron counters, opens the spike-injection window for a fixed number of integration cycles per timestep, and asserts `global_leak_time` for the leak window after each step. After the last step it holds `global_leak_time` long enough for the downstream 10-state argmax to finish, then reports completion. It produces the `global_leak_time` and counter-clear (`Memory_CLK`) signals consumed by the counter stage.

## Interface
Parameters:
- `STEP_CYCLES`, default 64: integration cycles per timestep, range 1..65535.
- `LEAK_CYCLES`, default 4: leak-window cycles per timestep, range 1..65535.
- `STEPS_PER_SAMPLE`, default 20: timesteps per sample, range 1..256.
- `CLR_CYCLES`, default 1: counter-clear cycles at sample start, range 1..65535.
- `RESULT_CYCLES`, default 12: final leak hold for the classifier, range 11..65535.

Ports:
- `CLK` in 1: clock.
- `RST_sync` in 1: reset, asynchronous, active-high.
- `start` in 1: request a new sample; sampled only in IDLE.
- `abort` in 1: terminate the current sample.
- `busy` out 1: high in every state except IDLE.
- `counter_clear` out 1: high during CLEAR; drives the counter stage's `Memory_CLK`.
- `spike_gate` out 1: high during INTEG; enables input spike injection.
- `global_leak_time` out 1: high during LEAK and DONE.
- `step_idx` out 8: current timestep, 0..STEPS_PER_SAMPLE-1.
- `sample_done` out 1: one-cycle completion pulse.
- `sample_count` out 16: number of completed samples.

## Operation
- All outputs are registered. Every output resets to 0, and the state resets to IDLE.
- Internal state: a 16-bit cycle counter `cyc` and the 8-bit `step_idx`.
- IDLE:
  - Strobes are low.
  - `start` and not `abort` → CLEAR, with `cyc`=0 and `step_idx`=0.
- CLEAR:
  - `counter_clear`=1 for CLR_CYCLES cycles, then → INTEG.
- INTEG:
  - `spike_gate`=1 for STEP_CYCLES cycles, then → LEAK.
- LEAK:
  - `global_leak_time`=1 for LEAK_CYCLES cycles.
  - At the end, if `step_idx`==STEPS_PER_SAMPLE-1 → DONE.
  - Otherwise `step_idx`+1 and → INTEG.
- DONE:
  - `global_leak_time`=1 for RESULT_CYCLES cycles.
  - Then → IDLE, with `sample_done`=1 for that single first IDLE cycle and `sample_count`+1.
  - `sample_count` wraps from 0xFFFF to 0x0000.
- `step_idx` holds its last value in DONE and IDLE, and is zeroed on entry to CLEAR.
- `abort` in any non-IDLE state → IDLE on the next edge:
  - all strobes drop in that cycle;
  - no `sample_done`;
  - `sample_count` is unchanged;
  - `step_idx` holds.
- Priority:
  - `abort` beats `start` in IDLE.
  - `start` while busy is ignored; it is not queued.
- `start` in the `sample_done` cycle is accepted, giving back-to-back samples with no gap beyond that one IDLE cycle.
- `RST_sync` asserted mid-sample takes effect immediately and asynchronously. All outputs go to 0 and the state goes to IDLE; no `sample_done` is generated.
- Exactly one of `counter_clear`, `spike_gate`, `global_leak_time` is high in any non-IDLE cycle. All three are low in IDLE.

## Timing
- `start` is sampled at edge 0. CLEAR occupies cycles 1..CLR_CYCLES.
- Each timestep is STEP_CYCLES+LEAK_CYCLES cycles.
- Latency from the `start` edge to `sample_done` is 1+CLR_CYCLES+STEPS_PER_SAMPLE·(STEP_CYCLES+LEAK_CYCLES)+RESULT_CYCLES cycles. With defaults this is 1374.
- `busy` rises one cycle after `start` is sampled. It falls in the same cycle `sample_done` rises.
- RESULT_CYCLES ≥ 11 guarantees the downstream argmax (entry cycle plus 10 compare states) completes inside the final leak window.
- `abort` latency is 1 cycle, measured as abort sampled to strobes low.

## Test plan
- Basic sample (STEP=4, LEAK=2, STEPS=3, CLR=1, RESULT=12), pulse `start` at cycle 0 → required response:
  - `counter_clear` high in cycle 1;
  - `spike_gate` high in cycles 2–5, 8–11, 14–17;
  - `global_leak_time` high in 6–7, 12–13, 18–31;
  - `step_idx` 0/1/2;
  - `sample_done` in cycle 32 and `sample_count`=1.
- Back-to-back: `start` held high continuously → second CLEAR in cycle 33, second `sample_done` in cycle 64, `sample_count`=2.
- Abort at cycle 10 (inside step 1 INTEG) → all strobes low from cycle 11, `busy`=0, no `sample_done`, `sample_count` unchanged; a later `start` yields a full 32-cycle sample.
- `start` pulsed at cycle 20 while busy → ignored; only one `sample_done`, at cycle 32. Also drive `start` and `abort` together in IDLE → remains IDLE.
- `RST_sync` asserted at cycle 15 → all outputs are 0 immediately and asynchronously, before the next edge; the state is IDLE after release.
- Wrap: preload 65535 completed samples, or force `sample_count`=0xFFFF, then run one sample → `sample_count`=0x0000 with `sample_done`=1.
